// File: rtl/wb_mem_checker_if.sv
// Wishbone B4 master-side bus bundle used by the memory checker.
// Latency: none, wires only.
// Backpressure: the slave stalls a beat by withholding ack, or uses err/rty.
interface wb_mem_checker_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0]   wb_adr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [dw-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_mem_checker.sv
// Wishbone initiator: writes seed^k to a memory region in bursts, then reads back and checks it.
// Latency: bus cycle one clock after start; one idle cycle between bursts; done pulses after the last read.
// Backpressure: each beat waits for ack; rty reissues the rest of the burst, err aborts the run.
module wb_mem_checker #(
    parameter int aw = 32,
    parameter int dw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          start_i,
    input  logic [aw-1:0] base_adr_i,
    input  logic [15:0]   words_i,
    input  logic [3:0]    burst_len_i,
    input  logic [dw-1:0] seed_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          fail_o,
    output logic [15:0]   err_cnt_o,
    output logic [aw-1:0] fail_adr_o,
    wb_mem_checker_if.master wb
);

    typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP, DONE} state_t;

    localparam logic [aw-1:0] STEP = aw'(dw / 8);

    state_t        state_q, state_d;
    logic [aw-1:0] base_q, base_d;
    logic [15:0]   words_q, words_d;
    logic [3:0]    blen_q, blen_d;
    logic [dw-1:0] seed_q, seed_d;
    logic [15:0]   k_q, k_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [3:0]    beat_rem_q, beat_rem_d;
    logic [3:0]    burst_sz_q, burst_sz_d;
    logic          retry_q, retry_d;
    logic          bus_err_q, bus_err_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [aw-1:0] fail_adr_q, fail_adr_d;

    logic          stb;
    logic          last_beat;
    logic [dw-1:0] exp_dat;
    logic [3:0]    nxt_beats;

    // Beats in the next burst: remaining words capped by the burst length (0 means 1).
    function automatic logic [3:0] burst_beats(input logic [15:0] left, input logic [3:0] bl);
        logic [3:0] b;
        b = (bl == 4'd0) ? 4'd1 : bl;
        return (left < {12'd0, b}) ? left[3:0] : b;
    endfunction

    assign stb       = (state_q == WRITE) || (state_q == READ);
    assign last_beat = (beat_rem_q == 4'd1);
    assign exp_dat   = seed_q ^ dw'(k_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        words_d    = words_q;
        blen_d     = blen_q;
        seed_d     = seed_q;
        k_d        = k_q;
        adr_d      = adr_q;
        beat_rem_d = beat_rem_q;
        burst_sz_d = burst_sz_q;
        retry_d    = retry_q;
        bus_err_d  = bus_err_q;
        err_cnt_d  = err_cnt_q;
        fail_adr_d = fail_adr_q;
        nxt_beats  = burst_beats(words_q - k_q, blen_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d     = base_adr_i;
                    words_d    = words_i;
                    blen_d     = burst_len_i;
                    seed_d     = seed_i;
                    k_d        = 16'd0;
                    adr_d      = base_adr_i;
                    err_cnt_d  = 16'd0;
                    bus_err_d  = 1'b0;
                    fail_adr_d = '0;
                    retry_d    = 1'b0;
                    burst_sz_d = burst_beats(words_i, burst_len_i);
                    beat_rem_d = burst_beats(words_i, burst_len_i);
                    state_d    = (words_i == 16'd0) ? WGAP : WRITE;
                end
            end
            WRITE, READ: begin
                if (wb.wb_err_i) begin
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else if (wb.wb_rty_i) begin
                    retry_d = 1'b1;
                    state_d = (state_q == WRITE) ? WGAP : RGAP;
                end else if (wb.wb_ack_i) begin
                    k_d        = k_q + 16'd1;
                    adr_d      = adr_q + STEP;
                    beat_rem_d = beat_rem_q - 4'd1;
                    if (state_q == READ && wb.wb_dat_i != exp_dat) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (err_cnt_q == 16'd0)    fail_adr_d = adr_q;
                    end
                    if (last_beat) begin
                        if (state_q == WRITE)             state_d = WGAP;
                        else if (k_q + 16'd1 == words_q)  state_d = DONE;
                        else                              state_d = RGAP;
                    end
                end
            end
            WGAP, RGAP: begin
                // A retried burst resumes with only its unfinished beats.
                if (retry_q) begin
                    retry_d    = 1'b0;
                    burst_sz_d = beat_rem_q;
                    state_d    = (state_q == WGAP) ? WRITE : READ;
                end else if (state_q == WGAP && k_q == words_q) begin
                    k_d        = 16'd0;
                    adr_d      = base_q;
                    burst_sz_d = burst_beats(words_q, blen_q);
                    beat_rem_d = burst_beats(words_q, blen_q);
                    state_d    = (words_q == 16'd0) ? DONE : READ;
                end else begin
                    burst_sz_d = nxt_beats;
                    beat_rem_d = nxt_beats;
                    state_d    = (state_q == WGAP) ? WRITE : READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            words_q    <= '0;
            blen_q     <= '0;
            seed_q     <= '0;
            k_q        <= '0;
            adr_q      <= '0;
            beat_rem_q <= '0;
            burst_sz_q <= '0;
            retry_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            err_cnt_q  <= '0;
            fail_adr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            words_q    <= words_d;
            blen_q     <= blen_d;
            seed_q     <= seed_d;
            k_q        <= k_d;
            adr_q      <= adr_d;
            beat_rem_q <= beat_rem_d;
            burst_sz_q <= burst_sz_d;
            retry_q    <= retry_d;
            bus_err_q  <= bus_err_d;
            err_cnt_q  <= err_cnt_d;
            fail_adr_q <= fail_adr_d;
        end
    end

    // Bus outputs decode straight from state so reset clears them without a clock.
    assign wb.wb_cyc_o = stb;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = (state_q == WRITE);
    assign wb.wb_adr_o = stb ? adr_q : '0;
    assign wb.wb_dat_o = (state_q == WRITE) ? exp_dat : '0;
    assign wb.wb_sel_o = {(dw / 8){stb}};
    assign wb.wb_bte_o = 2'b00;
    assign wb.wb_cti_o = !stb                  ? 3'b000 :
                         (burst_sz_q == 4'd1)  ? 3'b000 :
                         last_beat             ? 3'b111 : 3'b010;

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign fail_o     = bus_err_q || (err_cnt_q != 16'd0);
    assign err_cnt_o  = err_cnt_q;
    assign fail_adr_o = fail_adr_q;

endmodule

// File: tb/tb_wb_mem_checker.sv
// Bench for wb_mem_checker: zero-wait memory slave with fault injection, table of runs plus trace sequences.
module tb_wb_mem_checker;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [15:0] words = '0;
    logic [3:0]  blen = '0;
    logic [31:0] seed = '0;
    logic        busy, done, fail;
    logic [15:0] err_cnt;
    logic [31:0] fail_adr;

    always #5 clk = ~clk;

    wb_mem_checker_if #(.aw(AW), .dw(DW)) wb ();

    wb_mem_checker #(.aw(AW), .dw(DW)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .base_adr_i(base),
        .words_i(words), .burst_len_i(blen), .seed_i(seed), .busy_o(busy),
        .done_o(done), .fail_o(fail), .err_cnt_o(err_cnt), .fail_adr_o(fail_adr), .wb(wb)
    );

    // Slave model: zero-wait memory, optional read corruption, err/rty on a chosen write beat.
    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    bit          rty_done = 1'b0;
    int          err_beat = 0, rty_beat = 0;
    logic [31:0] cor0 = NONE, cor1 = NONE;
    logic        act;

    always_comb begin
        act = wb.wb_cyc_o & wb.wb_stb_o;
        wb.wb_err_i = act & wb.wb_we_o & (err_beat != 0) & (wr_cnt == err_beat - 1);
        wb.wb_rty_i = act & wb.wb_we_o & (rty_beat != 0) & !rty_done & (wr_cnt == rty_beat - 1);
        wb.wb_ack_i = act & !wb.wb_err_i & !wb.wb_rty_i;
        wb.wb_dat_i = '0;
        if (act && !wb.wb_we_o)
            wb.wb_dat_i = mem[wb.wb_adr_o[9:2]] ^
                          (((wb.wb_adr_o == cor0) || (wb.wb_adr_o == cor1)) ? 32'h0000_00FF : 32'h0);
    end

    always @(posedge clk) begin
        if (start && !busy) begin
            wr_cnt   <= 0;
            rty_done <= 1'b0;
        end else if (act && wb.wb_we_o) begin
            if (wb.wb_rty_i) rty_done <= 1'b1;
            else if (wb.wb_ack_i) begin
                wr_cnt <= wr_cnt + 1;
                mem[wb.wb_adr_o[9:2]] <= wb.wb_dat_o;
            end
        end
    end

    // Bus monitor: logs every completed beat, sampled mid-cycle.
    int          cyc_no = 0, wr_n = 0, rd_n = 0, cyc_hi_n = 0;
    logic [31:0] wr_adr [0:511];
    logic [31:0] wr_dat [0:511];
    logic [2:0]  wr_cti [0:511];
    int          wr_cyc [0:511];
    logic [31:0] rd_adr [0:511];
    logic [2:0]  rd_cti [0:511];

    always @(negedge clk) begin
        cyc_no <= cyc_no + 1;
        if (wb.wb_cyc_o) cyc_hi_n <= cyc_hi_n + 1;
        if (act && wb.wb_ack_i) begin
            if (wb.wb_we_o && wr_n < 512) begin
                wr_adr[wr_n] <= wb.wb_adr_o;
                wr_dat[wr_n] <= wb.wb_dat_o;
                wr_cti[wr_n] <= wb.wb_cti_o;
                wr_cyc[wr_n] <= cyc_no;
                wr_n <= wr_n + 1;
            end else if (!wb.wb_we_o && rd_n < 512) begin
                rd_adr[rd_n] <= wb.wb_adr_o;
                rd_cti[rd_n] <= wb.wb_cti_o;
                rd_n <= rd_n + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] words;
        logic [3:0]  blen;
        logic [31:0] seed;
        logic [31:0] cor0, cor1;
        int          err_beat, rty_beat;
        int          exp_wr, exp_rd, exp_cyc_hi, exp_lat;
        logic [15:0] exp_err_cnt;
        logic        exp_fail;
        logic [31:0] exp_fail_adr;
        logic [2:0]  exp_cti0;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int i, output int w0, output int r0);
        vec_t v;
        int   h0, lat;
        v = vecs[i];
        @(negedge clk);
        err_beat = v.err_beat; rty_beat = v.rty_beat; cor0 = v.cor0; cor1 = v.cor1;
        base = v.base; words = v.words; blen = v.blen; seed = v.seed; start = 1'b1;
        w0 = wr_n; r0 = rd_n; h0 = cyc_hi_n;
        lat = 0;
        // A second start with different controls arrives while busy and must be ignored.
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                base = 32'h300; words = 16'd7; blen = 4'd2; seed = 32'h0;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat < 400);
        start = 1'b0;
        chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
        chk($sformatf("v%0d_busy_after", i), busy, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_err_cnt", i), err_cnt, v.exp_err_cnt);
        chk($sformatf("v%0d_fail", i), fail, v.exp_fail);
        chk($sformatf("v%0d_fail_adr", i), fail_adr, v.exp_fail_adr);
        chk($sformatf("v%0d_wr_beats", i), wr_n - w0, v.exp_wr);
        chk($sformatf("v%0d_rd_beats", i), rd_n - r0, v.exp_rd);
        chk($sformatf("v%0d_cyc_cycles", i), cyc_hi_n - h0, v.exp_cyc_hi);
        if (v.exp_wr > 0) chk($sformatf("v%0d_first_cti", i), wr_cti[w0], v.exp_cti0);
    endtask

    initial begin
        int          w0, r0;
        logic [2:0]  cti5 [5];
        logic [2:0]  cti_rty [4];
        cti5    = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b000};
        cti_rty = '{3'b010, 3'b010, 3'b010, 3'b111};

        //            base          words  blen  seed          cor0          cor1          eb rb wr rd hi lat err     fail adr           cti0
        vecs[0] = '{32'h100, 16'd5, 4'd4, 32'hA5A5A5A5, NONE,         NONE,         0, 0, 5, 5, 10, 14, 16'd0, 1'b0, 32'h0,   3'b010};
        vecs[1] = '{32'h100, 16'd5, 4'd4, 32'hA5A5A5A5, 32'h108,      32'h10C,      0, 0, 5, 5, 10, 14, 16'd2, 1'b1, 32'h108, 3'b010};
        vecs[2] = '{32'h100, 16'd5, 4'd4, 32'hA5A5A5A5, NONE,         NONE,         3, 0, 2, 0, 3,  4,  16'd0, 1'b1, 32'h0,   3'b010};
        vecs[3] = '{32'h100, 16'd4, 4'd4, 32'h12345678, NONE,         NONE,         0, 2, 4, 4, 9,  12, 16'd0, 1'b0, 32'h0,   3'b010};
        vecs[4] = '{32'h100, 16'd0, 4'd4, 32'hA5A5A5A5, NONE,         NONE,         0, 0, 0, 0, 0,  2,  16'd0, 1'b0, 32'h0,   3'b000};
        vecs[5] = '{32'h200, 16'd3, 4'd0, 32'h00000000, NONE,         NONE,         0, 0, 3, 3, 6,  12, 16'd0, 1'b0, 32'h0,   3'b000};
        vecs[6] = '{32'h040, 16'd3, 4'd8, 32'hFFFF0000, 32'h048,      NONE,         0, 0, 3, 3, 6,  8,  16'd1, 1'b1, 32'h48,  3'b010};

        #12;
        chk("rst_cyc", wb.wb_cyc_o, 1'b0);
        chk("rst_stb", wb.wb_stb_o, 1'b0);
        chk("rst_we", wb.wb_we_o, 1'b0);
        chk("rst_adr", wb.wb_adr_o, 32'h0);
        chk("rst_sel", wb.wb_sel_o, 4'h0);
        chk("rst_cti", wb.wb_cti_o, 3'b000);
        chk("rst_bte", wb.wb_bte_o, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'h0);
        chk("rst_fail_adr", fail_adr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, w0, r0);
            if (i == 0) begin
                for (int j = 0; j < 5; j++) begin
                    chk($sformatf("trace_wr_adr%0d", j), wr_adr[w0 + j], 32'h100 + 32'(4 * j));
                    chk($sformatf("trace_wr_dat%0d", j), wr_dat[w0 + j], 32'hA5A5A5A5 ^ 32'(j));
                    chk($sformatf("trace_wr_cti%0d", j), wr_cti[w0 + j], cti5[j]);
                    chk($sformatf("trace_rd_adr%0d", j), rd_adr[r0 + j], 32'h100 + 32'(4 * j));
                    chk($sformatf("trace_rd_cti%0d", j), rd_cti[r0 + j], cti5[j]);
                end
                chk("trace_back_to_back", wr_cyc[w0 + 1] - wr_cyc[w0], 1);
                chk("trace_burst_gap", wr_cyc[w0 + 4] - wr_cyc[w0 + 3], 2);
            end
            if (i == 3) begin
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("rty_wr_adr%0d", j), wr_adr[w0 + j], 32'h100 + 32'(4 * j));
                    chk($sformatf("rty_wr_cti%0d", j), wr_cti[w0 + j], cti_rty[j]);
                end
                chk("rty_idle_gap", wr_cyc[w0 + 1] - wr_cyc[w0], 3);
            end
        end

        // Reset in the middle of a burst clears the bus without a clock edge.
        @(negedge clk);
        err_beat = 0; rty_beat = 0; cor0 = NONE; cor1 = NONE;
        base = 32'h100; words = 16'd5; blen = 4'd4; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_cyc_before_rst", wb.wb_cyc_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", wb.wb_cyc_o, 1'b0);
        chk("mid_rst_stb", wb.wb_stb_o, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, w0, r0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_mem_checker.md
WB_MEM_CHECKER -- requirements
Module: wb_mem_checker

Interface
REQ-001 SHALL have parameter aw, default 32, Wishbone address width.
REQ-002 SHALL have parameter dw, default 32, Wishbone data width; byte lane count is dw/8.
REQ-003 SHALL have ports: wb_clk_i in 1 clock; wb_rst_ni in 1 reset. The block uses one clock, and reset is asynchronous and active-low.
REQ-004 SHALL have control ports: start_i in 1 start pulse; base_adr_i in aw word-aligned start address; words_i in 16 word count; burst_len_i in 4 beats per burst; seed_i in dw pattern seed.
REQ-005 SHALL have status ports: busy_o out 1; done_o out 1 one-cycle completion pulse; fail_o out 1; err_cnt_o out 16 mismatch count; fail_adr_o out aw first mismatching address.
REQ-006 SHALL have master ports: wb_adr_o out aw; wb_dat_o out dw; wb_sel_o out dw/8; wb_we_o out 1; wb_cyc_o out 1; wb_stb_o out 1; wb_cti_o out 3; wb_bte_o out 2.
REQ-007 SHALL have master inputs: wb_dat_i in dw; wb_ack_i in 1; wb_err_i in 1; wb_rty_i in 1.

Function
REQ-008 SHALL be the Wishbone initiator that writes a pattern to a slave memory region and then reads it back and checks it.
REQ-009 SHALL implement the states IDLE, WRITE, WGAP, READ, RGAP and DONE.
REQ-010 SHALL sample start_i only in IDLE; start_i while busy_o=1 is ignored.
REQ-011 On start, SHALL latch all control inputs and clear err_cnt_o, fail_o and fail_adr_o.
REQ-012 On start, SHALL assert cyc/stb on the next clock, with we=1 and address base_adr_i.
REQ-013 SHALL treat burst_len_i=0 as 1.
REQ-014 Each burst SHALL carry min(remaining words, burst_len) beats at incrementing addresses with a step of dw/8.
REQ-015 For bursts of 2 or more beats, SHALL drive wb_cti_o=3'b010 on every beat except the last and 3'b111 on the last beat. A single-beat burst SHALL use 3'b000.
REQ-016 wb_bte_o SHALL be 2'b00 at all times; wb_sel_o SHALL be all ones while stb=1.
REQ-017 Expected data for word index k (0-based) SHALL be seed ^ k, with k zero-extended to dw bits.
REQ-018 stb SHALL stay high across the beats of a burst. A beat completes on the clock edge where ack=1. The next beat's address, data and cti SHALL be presented on the following cycle.
REQ-019 After the last ack of a burst, cyc and stb SHALL drop for exactly one cycle (WGAP or RGAP) before the next burst starts.
REQ-020 After the final write burst, SHALL enter the READ phase at base_adr_i with we=0 and k reset to 0.
REQ-021 In READ, on each ack, SHALL compare wb_dat_i with the expected data for k. On mismatch, err_cnt_o SHALL increment, saturating at 16'hFFFF. fail_adr_o SHALL capture the beat address on the first mismatch only.
REQ-022 On rty=1, SHALL drop cyc for one cycle and then reissue the remaining beats of that burst from the current address. The cti encoding SHALL be recomputed for the shortened burst. The retried beat is not counted.
REQ-023 On err=1 in either phase, SHALL drop cyc/stb on the next cycle, set fail_o, and go to DONE without checking further.
REQ-024 If ack, err and rty are asserted together, priority SHALL be err > rty > ack.
REQ-025 If words_i=0, SHALL generate no bus activity and pulse done_o 2 cycles after start with fail_o=0.
REQ-026 DONE SHALL pulse done_o for one cycle and then return to IDLE.
REQ-027 fail_o SHALL be 1 if a bus error occurred or err_cnt_o is nonzero.
REQ-028 Status outputs SHALL hold their values until the next accepted start.
REQ-029 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-030 While wb_rst_ni=0, SHALL asynchronously force the following outputs to 0: all Wishbone outputs (cti=000, bte=00), busy_o, done_o, fail_o, err_cnt_o and fail_adr_o. The state SHALL be IDLE.
REQ-031 A reset during a burst SHALL drop cyc/stb immediately, without waiting for the clock.
REQ-032 After reset release, the first accepted start SHALL be the one sampled on or after the first rising clock edge.

Verification
REQ-033 Zero-wait-state memory slave; base=0x100, words=5, burst=4, seed=0xA5A5A5A5 -> required bus activity:
  - Writes: 0x100-0x10C with cti 010,010,010,111, then a 1-cycle gap, then 0x110 with cti 000.
  - Data: 0xA5A5A5A5 through 0xA5A5A5A1.
  - Reads: the same sequence.
  - Result: done_o pulses with fail_o=0 and err_cnt_o=0.
REQ-034 Same as REQ-033, but the slave corrupts the read data at 0x108 and 0x10C -> err_cnt_o=2, fail_adr_o=0x108, fail_o=1.
REQ-035 Slave asserts err on the 3rd write beat -> cyc drops the next cycle; done_o pulses with fail_o=1; no read cycles occur.
REQ-036 Slave asserts rty on the 2nd beat of a 4-beat burst -> 1 idle cycle, then beats 2-4 are reissued from base+4 with cti 010,010,111; the final check passes.
REQ-037 words=0 -> no cyc; done_o pulses 2 cycles after start. Separately: wb_rst_ni=0 mid-burst -> cyc and stb go to 0 immediately, and busy_o=0.
